// File: rtl/therm_pkg.sv
// Shared definitions for the thermometer-code encode/decode arbiter.
package therm_pkg;

    localparam int unsigned K_DEFAULT = 3;
    localparam int unsigned W_DEFAULT = 2**K_DEFAULT - 1;

    typedef enum logic {
        OP_ENC = 1'b0,
        OP_DEC = 1'b1
    } op_e;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StExec = 2'd1,
        StResp = 2'd2
    } state_e;

endpackage

// File: rtl/therm_codec.sv
// Combinational binary <-> thermometer codec, time-shared by both requesters.
module therm_codec
    import therm_pkg::*;
#(
    parameter int unsigned K = K_DEFAULT,
    parameter int unsigned W = 2**K - 1
) (
    input  op_e            op,
    input  logic [W-1:0]   operand,
    output logic [W-1:0]   result,
    output logic           err
);

    logic [K-1:0] enc_n;
    logic [W-1:0] enc_code;
    logic [K-1:0] dec_cnt;
    logic         dec_legal;

    always_comb begin
        enc_n    = operand[K-1:0];
        enc_code = '0;
        for (int unsigned i = 0; i < W; i++) begin
            enc_code[i] = (i < 32'(enc_n));
        end
    end

    // Decode count is the highest set bit + 1; the code is legal only if every
    // bit below that point is set.
    always_comb begin
        dec_cnt = '0;
        for (int unsigned i = 0; i < W; i++) begin
            if (operand[i]) begin
                dec_cnt = K'(i + 1);
            end
        end
        dec_legal = 1'b1;
        for (int unsigned i = 0; i < W; i++) begin
            if (operand[i] != (i < 32'(dec_cnt))) begin
                dec_legal = 1'b0;
            end
        end
    end

    always_comb begin
        result = enc_code;
        err    = 1'b0;
        if (op == OP_DEC) begin
            result = W'(dec_cnt);
            err    = ~dec_legal;
        end
    end

endmodule

// File: rtl/therm_arbiter.sv
// Two-requester round-robin arbiter in front of a shared thermometer codec.
module therm_arbiter
    import therm_pkg::*;
#(
    parameter int unsigned K = K_DEFAULT,
    parameter int unsigned W = 2**K - 1
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [1:0]     req_valid,
    output logic [1:0]     req_ready,
    input  logic [1:0]     req_op,
    input  logic [2*W-1:0] req_data,
    output logic           rsp_valid,
    input  logic           rsp_ready,
    output logic           rsp_id,
    output logic [W-1:0]   rsp_data,
    output logic           rsp_err
);

    state_e       state_q, state_d;
    logic         prio_q, prio_d;
    op_e          op_q;
    logic [W-1:0] opnd_q;
    logic         id_q;
    logic         rsp_id_q;
    logic [W-1:0] rsp_data_q;
    logic         rsp_err_q;

    logic         grant_id;
    logic         capture;
    logic         load_rsp;
    logic [W-1:0] codec_result;
    logic         codec_err;

    therm_codec #(
        .K (K),
        .W (W)
    ) u_codec (
        .op      (op_q),
        .operand (opnd_q),
        .result  (codec_result),
        .err     (codec_err)
    );

    always_comb begin
        grant_id = 1'b0;
        unique case (req_valid)
            2'b10:   grant_id = 1'b1;
            2'b11:   grant_id = prio_q;
            default: grant_id = 1'b0;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        prio_d    = prio_q;
        req_ready = 2'b00;
        rsp_valid = 1'b0;
        capture   = 1'b0;
        load_rsp  = 1'b0;
        unique case (state_q)
            StIdle: begin
                // req_ready is combinational, so it must also be masked while reset is held.
                if (rst_n && (req_valid != 2'b00)) begin
                    req_ready[grant_id] = 1'b1;
                    capture             = 1'b1;
                    state_d             = StExec;
                end
            end
            StExec: begin
                load_rsp = 1'b1;
                state_d  = StResp;
            end
            StResp: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_d = StIdle;
                    prio_d  = ~rsp_id_q;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            prio_q     <= 1'b0;
            op_q       <= OP_ENC;
            opnd_q     <= '0;
            id_q       <= 1'b0;
            rsp_id_q   <= 1'b0;
            rsp_data_q <= '0;
            rsp_err_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            prio_q  <= prio_d;
            if (capture) begin
                op_q   <= op_e'(req_op[grant_id]);
                opnd_q <= grant_id ? req_data[2*W-1:W] : req_data[W-1:0];
                id_q   <= grant_id;
            end
            if (load_rsp) begin
                rsp_id_q   <= id_q;
                rsp_data_q <= codec_result;
                rsp_err_q  <= codec_err;
            end
        end
    end

    assign rsp_id   = rsp_id_q;
    assign rsp_data = rsp_data_q;
    assign rsp_err  = rsp_err_q;

endmodule

// File: tb/tb_therm_arbiter.sv
// Self-checking bench: transaction-level model compared every cycle plus directed literals.
module tb_therm_arbiter;

    localparam int unsigned K = 3;
    localparam int unsigned W = 7;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [1:0]     req_valid;
    logic [1:0]     req_ready;
    logic [1:0]     req_op;
    logic [2*W-1:0] req_data;
    logic           rsp_valid;
    logic           rsp_ready;
    logic           rsp_id;
    logic [W-1:0]   rsp_data;
    logic           rsp_err;

    int checks = 0;
    int errors = 0;

    therm_arbiter #(
        .K (K),
        .W (W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .req_data  (req_data),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_data  (rsp_data),
        .rsp_err   (rsp_err)
    );

    always #5 clk = ~clk;

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference arithmetic: encode = 2^n - 1, decode = bit length of the operand.
    function automatic int unsigned ref_data(input logic op, input logic [W-1:0] opnd);
        int unsigned v;
        int unsigned cnt;
        v = 32'(opnd);
        if (op == 1'b0) begin
            return (32'd1 << (v % (32'd1 << K))) - 1;
        end
        cnt = 0;
        while ((v >> cnt) != 0) cnt++;
        return cnt;
    endfunction

    function automatic bit ref_err(input logic op, input logic [W-1:0] opnd);
        int unsigned v;
        int unsigned cnt;
        if (op == 1'b0) return 1'b0;
        v   = 32'(opnd);
        cnt = 0;
        while ((v >> cnt) != 0) cnt++;
        return v != ((32'd1 << cnt) - 1);
    endfunction

    function automatic int winner(input logic [1:0] v, input bit p);
        if (v == 2'b11) return int'(p);
        if (v[0]) return 0;
        if (v[1]) return 1;
        return -1;
    endfunction

    // Model: one transaction at a time; grant in an idle cycle, result visible
    // from the second edge after the grant until the consumer takes it.
    bit           m_busy;
    int           m_ticks;
    bit           m_id;
    int unsigned  m_data;
    bit           m_err;
    bit           m_prio;
    int           m_win;
    logic         m_op;
    logic [W-1:0] m_opnd;
    logic [1:0]   exp_ready;
    logic         exp_valid;

    assign m_win     = winner(req_valid, m_prio);
    assign m_op      = (m_win == 1) ? req_op[1] : req_op[0];
    assign m_opnd    = (m_win == 1) ? req_data[2*W-1:W] : req_data[W-1:0];
    assign exp_ready = (m_busy || m_win < 0) ? 2'b00 : ((m_win == 1) ? 2'b10 : 2'b01);
    assign exp_valid = m_busy && (m_ticks >= 2);

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy  <= 1'b0;
            m_ticks <= 0;
            m_prio  <= 1'b0;
        end else if (!m_busy) begin
            if (m_win >= 0) begin
                m_busy  <= 1'b1;
                m_ticks <= 1;
                m_id    <= (m_win == 1);
                m_data  <= ref_data(m_op, m_opnd);
                m_err   <= ref_err(m_op, m_opnd);
            end
        end else if (m_ticks == 1) begin
            m_ticks <= 2;
        end else if (rsp_ready) begin
            m_busy <= 1'b0;
            m_prio <= ~m_id;
        end
    end

    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            cmp("model req_ready", req_ready, exp_ready);
            cmp("model rsp_valid", rsp_valid, exp_valid);
            if (exp_valid) begin
                cmp("model rsp_id", rsp_id, m_id);
                cmp("model rsp_data", rsp_data, m_data);
                cmp("model rsp_err", rsp_err, m_err);
            end
        end
    end

    task automatic do_txn(input bit id, input bit op, input logic [W-1:0] opnd,
                          input logic [W-1:0] exp_data, input bit exp_err, input string name);
        int k;
        bit got;
        req_valid[id] = 1'b1;
        req_op[id]    = op;
        if (id) req_data[2*W-1:W] = opnd;
        else    req_data[W-1:0]   = opnd;
        #1;
        got = 1'b0;
        for (k = 0; k < 20; k++) begin
            if (req_ready[id]) begin
                got = 1'b1;
                break;
            end
            @(negedge clk);
        end
        cmp({name, " grant"}, 32'(got), 32'd1);
        if (!got) return;
        @(posedge clk);
        #2 req_valid[id] = 1'b0;
        got = 1'b0;
        for (k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (rsp_valid) begin
                got = 1'b1;
                break;
            end
        end
        cmp({name, " latency"}, 32'(k), 32'd2);
        if (!got) return;
        cmp({name, " id"}, 32'(rsp_id), 32'(id));
        cmp({name, " data"}, 32'(rsp_data), 32'(exp_data));
        cmp({name, " err"}, 32'(rsp_err), 32'(exp_err));
        rsp_ready = 1'b1;
        @(posedge clk);
        #2 rsp_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int ids[6];
        int cyc[6];
        int n;
        bit got;

        rst_n     = 1'b0;
        req_valid = 2'b01;
        req_op    = 2'b00;
        req_data  = '0;
        rsp_ready = 1'b0;
        repeat (2) @(negedge clk);
        cmp("reset req_ready", 32'(req_ready), 32'd0);
        cmp("reset rsp_valid", 32'(rsp_valid), 32'd0);
        cmp("reset rsp_id", 32'(rsp_id), 32'd0);
        cmp("reset rsp_data", 32'(rsp_data), 32'd0);
        cmp("reset rsp_err", 32'(rsp_err), 32'd0);
        #1 rst_n = 1'b1;
        #1 cmp("first grant ready", 32'(req_ready), 32'd1);

        do_txn(1'b0, 1'b0, 7'd5,        7'b0011111, 1'b0, "enc5");
        do_txn(1'b1, 1'b1, 7'b0000111,  7'd3,       1'b0, "dec3");
        do_txn(1'b1, 1'b1, 7'b0101000,  7'd6,       1'b1, "dec_bad");
        do_txn(1'b0, 1'b0, 7'd0,        7'b0000000, 1'b0, "enc0");
        do_txn(1'b0, 1'b0, 7'd7,        7'b1111111, 1'b0, "enc7");
        do_txn(1'b1, 1'b1, 7'b0000000,  7'd0,       1'b0, "dec0");
        do_txn(1'b1, 1'b1, 7'b1111111,  7'd7,       1'b0, "dec7");
        do_txn(1'b1, 1'b1, 7'b0000010,  7'd2,       1'b1, "dec_gap");
        do_txn(1'b0, 1'b0, 7'b1111010,  7'b0000011, 1'b0, "enc_lowbits");

        // Both requesters continuously valid; last winner was 0, so 1 goes first.
        req_op    = 2'b10;
        req_data  = {7'b0001111, 7'd3};
        req_valid = 2'b11;
        rsp_ready = 1'b1;
        n = 0;
        for (int c = 0; c < 40 && n < 6; c++) begin
            @(negedge clk);
            if (rsp_valid) begin
                ids[n] = int'(rsp_id);
                cyc[n] = c;
                cmp("rr data", 32'(rsp_data), (rsp_id ? 32'd4 : 32'b0000111));
                n++;
            end
        end
        cmp("rr count", 32'(n), 32'd6);
        req_valid = 2'b00;
        @(posedge clk);
        #2 rsp_ready = 1'b0;
        if (n == 6) begin
            cmp("rr first id", 32'(ids[0]), 32'd1);
            for (int i = 1; i < 6; i++) begin
                cmp("rr alternate", 32'(ids[i]), 32'(1 - ids[i-1]));
                cmp("rr spacing", 32'(cyc[i] - cyc[i-1]), 32'd3);
            end
        end

        // Stall in RESP with requester 0 waiting behind requester 1.
        req_op    = 2'b10;
        req_data  = {7'b0011111, 7'd2};
        req_valid = 2'b11;
        got = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (rsp_valid) begin
                got = 1'b1;
                break;
            end
        end
        cmp("stall rsp seen", 32'(got), 32'd1);
        req_valid = 2'b01;
        cmp("stall id", 32'(rsp_id), 32'd1);
        cmp("stall data", 32'(rsp_data), 32'd5);
        repeat (5) begin
            @(negedge clk);
            cmp("stall valid", 32'(rsp_valid), 32'd1);
            cmp("stall hold data", 32'(rsp_data), 32'd5);
            cmp("stall req_ready", 32'(req_ready), 32'd0);
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        #2 rsp_ready = 1'b0;
        @(negedge clk);
        cmp("after stall grant", 32'(req_ready), 32'd1);
        do_txn(1'b0, 1'b0, 7'd2, 7'b0000011, 1'b0, "after_stall");

        // Reset pulse while the transaction sits in EXEC.
        req_op[1]         = 1'b0;
        req_data[2*W-1:W] = 7'd4;
        req_valid         = 2'b10;
        @(posedge clk);
        #2 req_valid = 2'b11;
        #1 rst_n = 1'b0;
        #1;
        cmp("async rst req_ready", 32'(req_ready), 32'd0);
        cmp("async rst rsp_valid", 32'(rsp_valid), 32'd0);
        cmp("async rst rsp_id", 32'(rsp_id), 32'd0);
        cmp("async rst rsp_data", 32'(rsp_data), 32'd0);
        cmp("async rst rsp_err", 32'(rsp_err), 32'd0);
        @(posedge clk);
        @(negedge clk);
        #1 rst_n = 1'b1;
        #1 cmp("prio after reset", 32'(req_ready), 32'd1);
        req_valid = 2'b01;
        do_txn(1'b0, 1'b0, 7'd1, 7'b0000001, 1'b0, "post_reset");

        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
